// File: rtl/alu_mc_if.sv
// ---------------------------------------------------------------------------
// alu_mc_if -- request/result bundle between the control unit and alu_mc.
//
// Signals:
//   start    request strobe, only honoured while busy=0
//   opcode   4-bit operation select
//   ar_flag  SHR mode: 1 = arithmetic, 0 = logical
//   src1     operand A
//   src2     operand B / shift amount
//   busy     iterative (MUL/DIV/MOD) operation in progress
//   done     one-cycle completion pulse
//   out      primary result
//   out_hi   MUL high half or DIV/MOD secondary result, 0 otherwise
//   flags    {O, C, N, Z}
//
// Modports: master = control unit side, slave = ALU side.
// ---------------------------------------------------------------------------
interface alu_mc_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       opcode;
    logic             ar_flag;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;
    logic [3:0]       flags;

    modport master (
        output start, opcode, ar_flag, src1, src2,
        input  busy, done, out, out_hi, flags
    );

    modport slave (
        input  start, opcode, ar_flag, src1, src2,
        output busy, done, out, out_hi, flags
    );
endinterface

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU, generic in WIDTH (>= 4, power of two).
//
// ADD/SUB/AND/OR/XOR/SHL/SHR complete in the cycle after start is sampled.
// MUL (shift-add) and DIV/MOD (restoring division) iterate for WIDTH cycles
// while busy=1, then pulse done. Results and flags are held between done
// pulses.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (aborts a running op without done)
//   bus  alu_mc_if.slave: start/opcode/ar_flag/src1/src2 in,
//        busy/done/out/out_hi/flags out
// ---------------------------------------------------------------------------
module alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_DIV = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_SHL = 4'b1010;
    localparam logic [3:0] OP_SHR = 4'b1011;
    localparam logic [3:0] OP_MOD = 4'b1100;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t             r_state, w_state_next;
    logic [CW-1:0]      r_cnt, w_cnt_next;
    logic [3:0]         r_op, w_op_next;
    logic [WIDTH-1:0]   r_b, w_b_next;
    logic               r_dz, w_dz_next;
    // Shared accumulator: MUL {product_hi, product_lo},
    // DIV/MOD {partial_remainder, dividend-shifting-into-quotient}.
    logic [2*WIDTH-1:0] r_acc, w_acc_next;

    logic [WIDTH-1:0]   r_out, w_out_next;
    logic [WIDTH-1:0]   r_out_hi, w_out_hi_next;
    logic [3:0]         r_flags, w_flags_next;
    logic               r_done, w_done_next;

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH-1:0] w_a, w_b;
    logic [WIDTH:0]   w_add, w_sub, w_shl, w_shr_l, w_shr_a;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c, w_alu_o;

    assign w_a   = bus.src1;
    assign w_b   = bus.src2;
    assign w_add = {1'b0, w_a} + {1'b0, w_b};
    assign w_sub = {1'b0, w_a} - {1'b0, w_b};
    // Shifting one extra bit position makes that bit the carry (last bit
    // shifted out). Out-of-range amounts fall out naturally: logical shifts
    // give 0 with C=0 beyond WIDTH, the arithmetic shift fills with the sign.
    assign w_shl   = {1'b0, w_a} << w_b;
    assign w_shr_l = {w_a, 1'b0} >> w_b;
    assign w_shr_a = $signed({w_a, 1'b0}) >>> w_b;

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_o   = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                w_alu_res = w_add[WIDTH-1:0];
                w_alu_c   = w_add[WIDTH];
                w_alu_o   = (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                            (w_add[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_sub[WIDTH-1:0];
                w_alu_c   = w_sub[WIDTH];
                w_alu_o   = (w_a[WIDTH-1] != w_b[WIDTH-1]) &&
                            (w_sub[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_AND: w_alu_res = w_a & w_b;
            OP_OR:  w_alu_res = w_a | w_b;
            OP_XOR: w_alu_res = w_a ^ w_b;
            OP_SHL: begin
                w_alu_res = w_shl[WIDTH-1:0];
                w_alu_c   = w_shl[WIDTH];
            end
            OP_SHR: begin
                if (bus.ar_flag) begin
                    w_alu_res = w_shr_a[WIDTH:1];
                    w_alu_c   = w_shr_a[0];
                end else begin
                    w_alu_res = w_shr_l[WIDTH:1];
                    w_alu_c   = w_shr_l[0];
                end
            end
            default: ;
        endcase
    end

    // ---------------- iterative datapath ----------------
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]     w_div_shift, w_div_trial;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_div_acc;

    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                       (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

    // A divisor of 0 always "fits", so the quotient fills with ones and the
    // remainder collects the dividend -- exactly the divide-by-zero result.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_b};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
    assign w_div_acc   = w_div_ge ?
                         {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1} :
                         {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    // ---------------- next-state / output logic ----------------
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_op_next     = r_op;
        w_b_next      = r_b;
        w_dz_next     = r_dz;
        w_acc_next    = r_acc;
        w_out_next    = r_out;
        w_out_hi_next = r_out_hi;
        w_flags_next  = r_flags;
        w_done_next   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.opcode == OP_MUL || bus.opcode == OP_DIV ||
                        bus.opcode == OP_MOD) begin
                        w_op_next    = bus.opcode;
                        w_b_next     = w_b;
                        w_dz_next    = (w_b == '0);
                        w_acc_next   = {{WIDTH{1'b0}}, w_a};
                        w_cnt_next   = CW'(WIDTH);
                        w_state_next = ST_RUN;
                    end else begin
                        w_out_next    = w_alu_res;
                        w_out_hi_next = '0;
                        w_flags_next  = {w_alu_o, w_alu_c, w_alu_res[WIDTH-1],
                                         (w_alu_res == '0)};
                        w_done_next   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                w_cnt_next = r_cnt - CW'(1);
                w_acc_next = (r_op == OP_MUL) ? w_mul_acc : w_div_acc;
                if (r_cnt == CW'(1)) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                    if (r_op == OP_MUL) begin
                        w_out_next    = w_acc_next[WIDTH-1:0];
                        w_out_hi_next = w_acc_next[2*WIDTH-1:WIDTH];
                        w_flags_next  = {(w_out_hi_next != '0), (w_out_hi_next != '0),
                                         w_out_next[WIDTH-1], (w_out_next == '0)};
                    end else begin
                        if (r_op == OP_DIV) begin
                            w_out_next    = w_acc_next[WIDTH-1:0];
                            w_out_hi_next = w_acc_next[2*WIDTH-1:WIDTH];
                        end else begin
                            w_out_next    = w_acc_next[2*WIDTH-1:WIDTH];
                            w_out_hi_next = w_acc_next[WIDTH-1:0];
                        end
                        w_flags_next = {r_dz, 1'b0, w_out_next[WIDTH-1],
                                        (w_out_next == '0)};
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_b      <= '0;
            r_dz     <= 1'b0;
            r_acc    <= '0;
            r_out    <= '0;
            r_out_hi <= '0;
            r_flags  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_op     <= w_op_next;
            r_b      <= w_b_next;
            r_dz     <= w_dz_next;
            r_acc    <= w_acc_next;
            r_out    <= w_out_next;
            r_out_hi <= w_out_hi_next;
            r_flags  <= w_flags_next;
            r_done   <= w_done_next;
        end
    end

    assign bus.busy   = (r_state == ST_RUN);
    assign bus.done   = r_done;
    assign bus.out    = r_out;
    assign bus.out_hi = r_out_hi;
    assign bus.flags  = r_flags;
endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc -- directed self-checking bench for alu_mc at WIDTH=16.
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, half a cycle away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_alu_mc;
    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_DIV = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_SHL = 4'b1010;
    localparam logic [3:0] OP_SHR = 4'b1011;
    localparam logic [3:0] OP_MOD = 4'b1100;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(16)) bus ();

    alu_mc #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stimulus helpers: called right after a falling edge, return right after
    // the falling edge in which the result is visible.
    task automatic run_single(input logic [3:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic ar);
        bus.opcode = op; bus.src1 = a; bus.src2 = b; bus.ar_flag = ar;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        $display("op=%b a=%h b=%h ar=%b -> done=%b busy=%b out=%h hi=%h flags=%b",
                 op, a, b, ar, bus.done, bus.busy, bus.out, bus.out_hi, bus.flags);
    endtask

    task automatic run_iter(input logic [3:0] op, input logic [15:0] a,
                            input logic [15:0] b, input bit poke,
                            output int cycles, output int busy_lows);
        bus.opcode = op; bus.src1 = a; bus.src2 = b; bus.ar_flag = 1'b0;
        bus.start = 1'b1;
        cycles = -1;
        busy_lows = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (poke && k == 5) begin
                bus.start = 1'b1; bus.opcode = OP_ADD;
                bus.src1 = 16'h0001; bus.src2 = 16'h0001;
            end
            if (bus.done) begin
                cycles = k;
                break;
            end
            if (!bus.busy) busy_lows++;
        end
        bus.start = 1'b0;
        $display("op=%b a=%h b=%h -> cycles=%0d out=%h hi=%h flags=%b",
                 op, a, b, cycles, bus.out, bus.out_hi, bus.flags);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0; bus.opcode = OP_NOP; bus.ar_flag = 1'b0;
        bus.src1 = '0; bus.src2 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++; $display("FAIL reset_ctl: got busy/done=%b%b expected 00", bus.busy, bus.done);
        end
        checks++;
        if ({bus.out, bus.out_hi, bus.flags} !== 36'h0) begin
            errors++; $display("FAIL reset_data: got out=%h hi=%h flags=%b expected 0", bus.out, bus.out_hi, bus.flags);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++; $display("FAIL idle_done: got %b expected 0", bus.done);
        end
    endtask

    task automatic test_add_overflow;
        run_single(OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
        checks++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            errors++; $display("FAIL add_ctl: got done/busy=%b%b expected 10", bus.done, bus.busy);
        end
        checks++;
        if (bus.out !== 16'h8000 || bus.out_hi !== 16'h0000) begin
            errors++; $display("FAIL add_out: got %h/%h expected 8000/0000", bus.out, bus.out_hi);
        end
        checks++;
        if (bus.flags !== 4'b1010) begin
            errors++; $display("FAIL add_flags: got %b expected 1010", bus.flags);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.out !== 16'h8000) begin
            errors++; $display("FAIL add_hold: got done=%b out=%h expected 0/8000", bus.done, bus.out);
        end
    endtask

    task automatic test_back_to_back;
        bus.opcode = OP_SUB; bus.src1 = 16'h0000; bus.src2 = 16'h0001; bus.start = 1'b1;
        @(negedge clk);
        bus.opcode = OP_ADD; bus.src1 = 16'hFFFF; bus.src2 = 16'h0001;
        $display("op=%b a=0000 b=0001 -> done=%b out=%h flags=%b", OP_SUB, bus.done, bus.out, bus.flags);
        checks++;
        if (bus.done !== 1'b1 || bus.out !== 16'hFFFF || bus.flags !== 4'b0110) begin
            errors++; $display("FAIL sub_b2b: got done=%b out=%h flags=%b expected 1/ffff/0110", bus.done, bus.out, bus.flags);
        end
        @(negedge clk);
        bus.start = 1'b0;
        $display("op=%b a=ffff b=0001 -> done=%b out=%h flags=%b", OP_ADD, bus.done, bus.out, bus.flags);
        checks++;
        if (bus.done !== 1'b1 || bus.out !== 16'h0000 || bus.flags !== 4'b0101) begin
            errors++; $display("FAIL add_b2b: got done=%b out=%h flags=%b expected 1/0000/0101", bus.done, bus.out, bus.flags);
        end
    endtask

    task automatic test_logic;
        run_single(OP_AND, 16'hF0F0, 16'h0FF0, 1'b0);
        checks++;
        if (bus.out !== 16'h00F0 || bus.flags !== 4'b0000) begin
            errors++; $display("FAIL and: got %h/%b expected 00f0/0000", bus.out, bus.flags);
        end
        run_single(OP_XOR, 16'hA5A5, 16'h0F0F, 1'b0);
        checks++;
        if (bus.out !== 16'hAAAA || bus.flags !== 4'b0010) begin
            errors++; $display("FAIL xor: got %h/%b expected aaaa/0010", bus.out, bus.flags);
        end
        run_single(OP_NOP, 16'h1234, 16'h5678, 1'b0);
        checks++;
        if (bus.done !== 1'b1 || bus.out !== 16'h0000 || bus.flags !== 4'b0001) begin
            errors++; $display("FAIL nop: got done=%b out=%h flags=%b expected 1/0000/0001", bus.done, bus.out, bus.flags);
        end
    endtask

    task automatic test_shift;
        run_single(OP_SHR, 16'h8001, 16'd1, 1'b1);
        checks++;
        if (bus.out !== 16'hC000 || bus.flags !== 4'b0110) begin
            errors++; $display("FAIL sra1: got %h/%b expected c000/0110", bus.out, bus.flags);
        end
        run_single(OP_SHR, 16'h8001, 16'd1, 1'b0);
        checks++;
        if (bus.out !== 16'h4000 || bus.flags !== 4'b0100) begin
            errors++; $display("FAIL srl1: got %h/%b expected 4000/0100", bus.out, bus.flags);
        end
        run_single(OP_SHR, 16'h8000, 16'd20, 1'b1);
        checks++;
        if (bus.out !== 16'hFFFF || bus.flags !== 4'b0110) begin
            errors++; $display("FAIL sra20: got %h/%b expected ffff/0110", bus.out, bus.flags);
        end
        run_single(OP_SHL, 16'h0001, 16'd16, 1'b0);
        checks++;
        if (bus.out !== 16'h0000 || bus.flags !== 4'b0101) begin
            errors++; $display("FAIL shl16: got %h/%b expected 0000/0101", bus.out, bus.flags);
        end
        run_single(OP_SHL, 16'h8421, 16'd4, 1'b0);
        checks++;
        if (bus.out !== 16'h4210 || bus.flags !== 4'b0000) begin
            errors++; $display("FAIL shl4: got %h/%b expected 4210/0000", bus.out, bus.flags);
        end
        run_single(OP_SHL, 16'h8421, 16'd0, 1'b0);
        checks++;
        if (bus.out !== 16'h8421 || bus.flags !== 4'b0010) begin
            errors++; $display("FAIL shl0: got %h/%b expected 8421/0010", bus.out, bus.flags);
        end
    endtask

    task automatic test_mul;
        int cyc, lows;
        run_iter(OP_MUL, 16'h1234, 16'h0100, 1'b1, cyc, lows);
        checks++;
        if (cyc !== 17 || lows !== 0) begin
            errors++; $display("FAIL mul_timing: got done at %0d busy_lows=%0d expected 17/0", cyc, lows);
        end
        checks++;
        if (bus.out !== 16'h3400 || bus.out_hi !== 16'h0012 || bus.flags !== 4'b1100) begin
            errors++; $display("FAIL mul_result: got %h/%h/%b expected 3400/0012/1100", bus.out, bus.out_hi, bus.flags);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL mul_dropped_start: got done=%b busy=%b expected 0/0", bus.done, bus.busy);
        end
    endtask

    task automatic test_div;
        int cyc, lows;
        run_iter(OP_DIV, 16'd1000, 16'd7, 1'b0, cyc, lows);
        checks++;
        if (cyc !== 17 || bus.out !== 16'd142 || bus.out_hi !== 16'd6 || bus.flags !== 4'b0000) begin
            errors++; $display("FAIL div: got cyc=%0d %h/%h/%b expected 17/008e/0006/0000", cyc, bus.out, bus.out_hi, bus.flags);
        end
        // Issued in the done cycle of the DIV.
        run_iter(OP_MOD, 16'd1000, 16'd7, 1'b0, cyc, lows);
        checks++;
        if (cyc !== 17 || bus.out !== 16'd6 || bus.out_hi !== 16'd142 || bus.flags !== 4'b0000) begin
            errors++; $display("FAIL mod: got cyc=%0d %h/%h/%b expected 17/0006/008e/0000", cyc, bus.out, bus.out_hi, bus.flags);
        end
        run_iter(OP_MOD, 16'h1234, 16'h0000, 1'b0, cyc, lows);
        checks++;
        if (cyc !== 17 || bus.out !== 16'h1234 || bus.out_hi !== 16'hFFFF || bus.flags !== 4'b1000) begin
            errors++; $display("FAIL mod_by_zero: got cyc=%0d %h/%h/%b expected 17/1234/ffff/1000", cyc, bus.out, bus.out_hi, bus.flags);
        end
        run_iter(OP_DIV, 16'h1234, 16'h0000, 1'b0, cyc, lows);
        checks++;
        if (cyc !== 17 || lows !== 0 || bus.out !== 16'hFFFF || bus.out_hi !== 16'h1234 || bus.flags !== 4'b1010) begin
            errors++; $display("FAIL div_by_zero: got cyc=%0d %h/%h/%b expected 17/ffff/1234/1010", cyc, bus.out, bus.out_hi, bus.flags);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mul;
        bit seen;
        bus.opcode = OP_MUL; bus.src1 = 16'h1234; bus.src2 = 16'h0100; bus.start = 1'b1;
        repeat (5) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL mid_mul_busy: got %b expected 1", bus.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("rst during MUL -> busy=%b done=%b out=%h hi=%h flags=%b", bus.busy, bus.done, bus.out, bus.out_hi, bus.flags);
        checks++;
        if ({bus.busy, bus.done} !== 2'b00 || {bus.out, bus.out_hi, bus.flags} !== 36'h0) begin
            errors++; $display("FAIL abort: got busy=%b done=%b out=%h hi=%h flags=%b expected all 0",
                               bus.busy, bus.done, bus.out, bus.out_hi, bus.flags);
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL abort_no_done: got activity=%b expected 0", seen);
        end
        run_single(OP_ADD, 16'd2, 16'd3, 1'b0);
        checks++;
        if (bus.done !== 1'b1 || bus.out !== 16'd5 || bus.flags !== 4'b0000) begin
            errors++; $display("FAIL add_after_abort: got done=%b out=%h flags=%b expected 1/0005/0000", bus.done, bus.out, bus.flags);
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_logic();
        test_shift();
        test_mul();
        test_div();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
